// File: rtl/nios2_debug_pkg.sv
// Shared types and jdo field positions for the Nios II debug OCI memory arbiter.
package nios2_debug_pkg;

  typedef enum logic [1:0] {IDLE, AVS_RD, JTAG_RD} state_e;

  typedef enum logic [1:0] {NONE, READ, WRITE} pend_e;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_debug_rr_arb2.sv
// Two-requester round-robin arbiter: on contention the requester that did not
// win last time is granted. Grants are only issued while arb_en_i is high.
module nios2_debug_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic req_jtag_i,
  input  logic req_avs_i,
  output logic gnt_jtag_o,
  output logic gnt_avs_o
);

  logic last_avs_q, last_avs_d;
  logic gnt_jtag, gnt_avs;

  always_comb begin
    gnt_jtag   = 1'b0;
    gnt_avs    = 1'b0;
    last_avs_d = last_avs_q;
    if (arb_en_i) begin
      if (req_jtag_i && req_avs_i) begin
        gnt_jtag = last_avs_q;
        gnt_avs  = ~last_avs_q;
      end else begin
        gnt_jtag = req_jtag_i;
        gnt_avs  = req_avs_i;
      end
      if (gnt_jtag) last_avs_d = 1'b0;
      else if (gnt_avs) last_avs_d = 1'b1;
    end
  end

  assign gnt_jtag_o = gnt_jtag;
  assign gnt_avs_o  = gnt_avs;

  // last_grant resets to JTAG, so the first contended round goes to Avalon
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_avs_q <= 1'b0;
    else       last_avs_q <= last_avs_d;
  end

endmodule

// File: rtl/nios2_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between unstallable JTAG commands (held
// in a one-deep command register) and the Avalon debug_mem slave (stalled).
module nios2_debug_ocimem_arbiter
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              ovr_clr,
  output logic              monitor_ready,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e              state_q, state_d;
  pend_e               pend_q, pend_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic [DATA_W-1:0]   jwdata_q, jwdata_d;
  logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
  logic                ready_q, ready_d;
  logic                overrun_q, overrun_d;
  logic                gnt_jtag, gnt_avs, pend_free;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  nios2_debug_rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .arb_en_i   ((state_q == IDLE) && !reset),
    .req_jtag_i (pend_q != NONE),
    .req_avs_i  (avs_read || avs_write),
    .gnt_jtag_o (gnt_jtag),
    .gnt_avs_o  (gnt_avs)
  );

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    jaddr_d         = jaddr_q;
    jwdata_d        = jwdata_q;
    mon_dreg_d      = mon_dreg_q;
    ready_d         = ready_q;
    overrun_d       = overrun_q & ~ovr_clr;
    ram_addr        = jaddr_q;
    ram_rd          = 1'b0;
    ram_wr          = 1'b0;
    ram_wdata       = jwdata_q;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_avs) begin
          ram_addr = avs_address;
          if (avs_write) begin
            ram_wr          = 1'b1;
            ram_wdata       = avs_writedata;
            avs_waitrequest = 1'b0;
          end else begin
            ram_rd  = 1'b1;
            state_d = AVS_RD;
          end
        end else if (gnt_jtag) begin
          pend_d = NONE;
          if (pend_q == WRITE) begin
            ram_wr  = 1'b1;
            jaddr_d = jaddr_q + ADDR_W'(1);
            ready_d = 1'b1;
          end else begin
            ram_rd  = 1'b1;
            state_d = JTAG_RD;
          end
        end
      end
      AVS_RD: begin
        avs_waitrequest = 1'b0;
        avs_readdata    = ram_rdata;
        state_d         = IDLE;
      end
      JTAG_RD: begin
        mon_dreg_d = ram_rdata;
        ready_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Capture after completion so a new command in the same cycle re-clears ready
    pend_free = (pend_q == NONE) || gnt_jtag;
    if (take_action_ocimem_a) begin
      if (pend_free) begin
        jaddr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
        if (jdo[JDO_RD_BIT]) begin
          pend_d  = READ;
          ready_d = 1'b0;
        end
      end else begin
        overrun_d = 1'b1;
      end
      if (take_action_ocimem_b) overrun_d = 1'b1;
    end else if (take_action_ocimem_b) begin
      if (pend_free) begin
        pend_d   = WRITE;
        jwdata_d = jdo[JDO_WDATA_LSB +: DATA_W];
        ready_d  = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (reset) begin
      ram_rd          = 1'b0;
      ram_wr          = 1'b0;
      avs_waitrequest = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= NONE;
      jaddr_q    <= '0;
      jwdata_q   <= '0;
      mon_dreg_q <= '0;
      ready_q    <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      jaddr_q    <= jaddr_d;
      jwdata_q   <= jwdata_d;
      mon_dreg_q <= mon_dreg_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
    end
  end

  assign monitor_ready = ready_q;
  assign mon_dreg      = mon_dreg_q;
  assign jtag_overrun  = overrun_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Scoreboarded bench: drivers push expected read data from a shadow-memory model,
// a negedge monitor pops and compares whenever the DUT returns read data.
module tb_nios2_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        take_action_ocimem_a, take_action_ocimem_b, ovr_clr;
  logic [37:0] jdo;
  logic        monitor_ready, jtag_overrun;
  logic [31:0] mon_dreg;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write, avs_waitrequest;
  logic [31:0] avs_writedata, avs_readdata;
  logic [7:0]  ram_addr;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] ram    [0:255];
  logic [31:0] shadow [0:255];
  int          jaddrM;
  logic [31:0] avsQ[$];
  logic [31:0] jtagQ[$];
  bit          jtagReadPending;
  int          checkCount = 0;
  int          passCount  = 0;

  always #5 clk = ~clk;

  nios2_debug_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
    .jdo(jdo), .ovr_clr(ovr_clr),
    .monitor_ready(monitor_ready), .mon_dreg(mon_dreg), .jtag_overrun(jtag_overrun),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Environment RAM: synchronous write, read data valid the cycle after ram_rd
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= ram[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checkCount++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic logic [37:0] mkJdo(input logic [7:0] addr, input bit rd, input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    j[35] = rd;
    if (addr != 8'h00 || rd) j[24:17] = addr;
    return j;
  endfunction

  initial begin : monitor
    bit prevReady = 1'b1;
    forever begin
      @(negedge clk);
      if (avs_read && !avs_waitrequest) begin
        if (avsQ.size() == 0) failNow("avs_unexpected_readdata");
        else checkOutput("avs_readdata", avs_readdata, avsQ.pop_front());
      end
      if (!prevReady && monitor_ready && jtagReadPending) begin
        jtagReadPending = 1'b0;
        if (jtagQ.size() == 0) failNow("jtag_unexpected_read");
        else checkOutput("mon_dreg", mon_dreg, jtagQ.pop_front());
      end
      prevReady = monitor_ready;
    end
  end

  task automatic avsWrite(input logic [7:0] addr, input logic [31:0] data, output int waits);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    shadow[addr] = data;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      waits++;
    end
    if (avs_waitrequest) failNow("avs_write_timeout");
    @(posedge clk); #1;
    avs_write = 1'b0;
  endtask

  task automatic avsRead(input logic [7:0] addr, output int waits);
    avs_address = addr; avs_read = 1'b1;
    avsQ.push_back(shadow[addr]);
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      waits++;
    end
    if (avs_waitrequest) failNow("avs_read_timeout");
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic waitReady(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (monitor_ready) break;
    end
    if (!monitor_ready) failNow(name);
    @(posedge clk); #1;
  endtask

  // isA=1: address load (optional read); isA=0: write data at the model's jaddr
  task automatic jtagCmd(input bit isA, input bit rd, input logic [7:0] addr, input logic [31:0] data, output int lat);
    if (isA) begin
      jdo = mkJdo(addr, rd, 32'h0);
      jaddrM = addr;
      if (rd) begin
        jtagQ.push_back(shadow[addr]);
        jtagReadPending = 1'b1;
      end
    end else begin
      jdo = mkJdo(8'h00, 1'b0, data);
      shadow[jaddrM] = data;
      jaddrM = (jaddrM + 1) % 256;
    end
    take_action_ocimem_a = isA;
    take_action_ocimem_b = !isA;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    lat = 0;
    if (isA && !rd) return;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) checkOutput("jtag_ready_cleared", {31'h0, monitor_ready}, 32'h0);
      if (monitor_ready) break;
    end
    if (!monitor_ready) failNow("jtag_cmd_timeout");
    @(posedge clk); #1;
  endtask

  task automatic arbTest();
    int lat, got, kind;
    logic [31:0] curData;
    jtagCmd(1'b1, 1'b0, 8'h40, 32'h0, lat);
    avs_address = 8'h90; avs_read = 1'b1;
    curData = $urandom;
    jdo = mkJdo(8'h00, 1'b0, curData);
    take_action_ocimem_b = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 6; i++) begin
      @(negedge clk);
      kind = -1;
      if (ram_rd && ram_addr == 8'h90) begin
        kind = 0;
        avsQ.push_back(shadow[8'h90]);
      end else if (ram_wr && ram_addr[7:4] == 4'h4) begin
        kind = 1;
        checkOutput("arb_jtag_addr", {24'h0, ram_addr}, jaddrM);
        checkOutput("arb_jtag_wdata", ram_wdata, curData);
        shadow[jaddrM] = curData;
        jaddrM = (jaddrM + 1) % 256;
      end
      if (kind >= 0) begin
        checkOutput("arb_grant_order", kind, got % 2);
        got++;
        if (kind == 1 && got < 6) begin
          curData = $urandom;
          jdo = mkJdo(8'h00, 1'b0, curData);
          take_action_ocimem_b = 1'b1;
        end
      end
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
      if (got == 6) avs_read = 1'b0;
    end
    avs_read = 1'b0;
    if (got < 6) failNow("arb_grant_timeout");
    waitReady("arb_ready_timeout");
  endtask

  task automatic applyStimulus();
    int w, lat;
    avsWrite(8'h10, 32'hDEADBEEF, w);
    checkOutput("avs_write_waits", w, 0);
    avsRead(8'h10, w);
    checkOutput("avs_read_waits", w, 1);

    jtagCmd(1'b1, 1'b0, 8'h05, 32'h0, lat);
    for (int i = 1; i <= 3; i++) begin
      jtagCmd(1'b0, 1'b0, 8'h00, i, lat);
      checkOutput("jtag_write_latency", lat, 2);
    end
    jtagCmd(1'b1, 1'b1, 8'h06, 32'h0, lat);
    checkOutput("jtag_read_latency", lat, 3);
    checkOutput("mon_dreg_at_06", mon_dreg, 32'h2);
    avsRead(8'h07, w);

    jtagCmd(1'b1, 1'b0, 8'hFF, 32'h0, lat);
    jtagCmd(1'b0, 1'b0, 8'h00, 32'hAAAA0001, lat);
    jtagCmd(1'b0, 1'b0, 8'h00, 32'hBBBB0002, lat);
    jtagCmd(1'b1, 1'b1, 8'h00, 32'h0, lat);
    avsRead(8'hFF, w);

    arbTest();

    // Second write arrives while the first waits behind an Avalon read
    jtagCmd(1'b1, 1'b0, 8'h50, 32'h0, lat);
    avs_address = 8'h90; avs_read = 1'b1;
    avsQ.push_back(shadow[8'h90]);
    jdo = mkJdo(8'h00, 1'b0, 32'h11111111);
    take_action_ocimem_b = 1'b1;
    shadow[8'h50] = 32'h11111111;
    jaddrM = 8'h51;
    @(posedge clk); #1;
    jdo = mkJdo(8'h00, 1'b0, 32'h22222222);
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    avs_read = 1'b0;
    @(negedge clk);
    checkOutput("overrun_set", {31'h0, jtag_overrun}, 32'h1);
    waitReady("overrun_write_timeout");
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    @(negedge clk);
    checkOutput("overrun_cleared", {31'h0, jtag_overrun}, 32'h0);
    @(posedge clk); #1;

    // a and b together with ovr_clr: a wins, b dropped, set beats clear
    jdo = mkJdo(8'h60, 1'b0, 32'h0);
    jdo[34:25] = 10'h2A5;
    take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1; ovr_clr = 1'b1;
    jaddrM = 8'h60;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
    checkOutput("overrun_set_beats_clear", {31'h0, jtag_overrun}, 32'h1);
    @(posedge clk); #1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    jtagCmd(1'b0, 1'b0, 8'h00, 32'h44444444, lat);
    jtagCmd(1'b1, 1'b1, 8'h50, 32'h0, lat);
    jtagCmd(1'b1, 1'b1, 8'h51, 32'h0, lat);
    jtagCmd(1'b1, 1'b1, 8'h60, 32'h0, lat);
    jtagCmd(1'b1, 1'b1, 8'h61, 32'h0, lat);
    checkOutput("overrun_after_clear", {31'h0, jtag_overrun}, 32'h0);
  endtask

  task automatic avsRandom();
    int w;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 1) == 1) avsWrite(8'($urandom_range(128, 191)), $urandom, w);
      else avsRead(8'($urandom_range(128, 191)), w);
    end
  endtask

  task automatic jtagRandom();
    int lat, r;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      r = $urandom_range(0, 3);
      if (r == 0) jtagCmd(1'b1, 1'b1, 8'($urandom_range(32, 63)), 32'h0, lat);
      else if (r == 1 || jaddrM < 32 || jaddrM > 62)
        jtagCmd(1'b1, 1'b0, 8'($urandom_range(32, 55)), 32'h0, lat);
      else jtagCmd(1'b0, 1'b0, 8'h00, $urandom, lat);
    end
  endtask

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passCount, checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int w;
    for (int i = 0; i < 256; i++) begin ram[i] = 32'h0; shadow[i] = 32'h0; end
    reset = 1'b1;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; ovr_clr = 1'b0;
    jdo = '0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    jaddrM = 0; jtagReadPending = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_monitor_ready", {31'h0, monitor_ready}, 32'h1);
    checkOutput("rst_mon_dreg", mon_dreg, 32'h0);
    checkOutput("rst_jtag_overrun", {31'h0, jtag_overrun}, 32'h0);
    checkOutput("rst_waitrequest", {31'h0, avs_waitrequest}, 32'h1);
    checkOutput("rst_ram_strobes", {30'h0, ram_rd, ram_wr}, 32'h0);
    @(posedge clk); #1;

    applyStimulus();

    fork
      avsRandom();
      jtagRandom();
    join

    // Reset lands in the cycle after an Avalon read grant
    avs_address = 8'h90; avs_read = 1'b1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checkOutput("midrd_waitrequest", {31'h0, avs_waitrequest}, 32'h1);
    checkOutput("midrd_ram_strobes", {30'h0, ram_rd, ram_wr}, 32'h0);
    checkOutput("midrd_monitor_ready", {31'h0, monitor_ready}, 32'h1);
    avs_read = 1'b0;
    avs_write = 1'b1; avs_address = 8'h91; avs_writedata = 32'hBAD0BAD0;
    @(negedge clk);
    checkOutput("inrst_no_write", {30'h0, ram_rd, ram_wr}, 32'h0);
    checkOutput("inrst_waitrequest", {31'h0, avs_waitrequest}, 32'h1);
    checkOutput("inrst_mon_dreg", mon_dreg, 32'h0);
    avs_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    jaddrM = 0;
    avsRead(8'h90, w);
    checkOutput("postrst_read_waits", w, 1);
    avsRead(8'h91, w);
    repeat (3) @(posedge clk);
    checkOutput("avs_queue_drained", avsQ.size(), 0);
    checkOutput("jtag_queue_drained", jtagQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
